rs_adder_scheduler: RTL

Time-shares one external WORD_W-bit carry-chain adder ($alu mapped onto ADDER_CARRY) among NREQ requesters. Each requester issues bursts of words, least-significant word first, to perform add/subtract operations wider than one chain. The block arbitrates round-robin per burst and holds the grant until the burst's last word. It drives the adder's A/B/CI/BI inputs, chains carry-out to the next word's carry-in, and registers results into a one-entry response slot.

---
 rtl/rs_adder_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rs_adder_scheduler.sv
// Round-robin scheduler sharing one carry-chain adder among NREQ requesters.
// Bursts run LSW first; carry-out of each word feeds the next word's carry-in.
module rs_adder_scheduler #(
    parameter int WORD_W = 32,
    parameter int NREQ   = 4,
    parameter int ID_W   = 2
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    input  logic [NREQ-1:0]        req_last,
    output logic [WORD_W-1:0]      adder_a,
    output logic [WORD_W-1:0]      adder_b,
    output logic                   adder_ci,
    output logic                   adder_bi,
    input  logic [WORD_W-1:0]      adder_y,
    input  logic                   adder_co,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_W-1:0]      rsp_y,
    output logic                   rsp_co,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_last
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            carry_reg;
    logic            sub_reg;
    logic            first;

    logic            pick_hit;
    logic [ID_W-1:0] pick_id;
    logic            slot_free;
    logic            g_valid;
    logic            g_sub;
    logic            g_last;
    logic            accept;
    logic [ID_W-1:0] ptr_nxt;

    // Scan from rr_ptr upward with wrap; descending loop lets lowest offset win.
    always_comb begin
        pick_hit = 1'b0;
        pick_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                pick_hit = 1'b1;
                pick_id  = ID_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign slot_free = ~rsp_valid | rsp_ready;
    assign g_valid   = req_valid[grant_id];
    assign g_sub     = req_sub[grant_id];
    assign g_last    = req_last[grant_id];
    assign accept    = (state == BURST) & g_valid & slot_free;
    assign ptr_nxt   = ID_W'((int'(grant_id) + 1) % NREQ);

    always_comb begin
        req_ready = '0;
        adder_a   = '0;
        adder_b   = '0;
        adder_ci  = 1'b0;
        adder_bi  = 1'b0;
        if (state == BURST) begin
            req_ready[grant_id] = slot_free;
            adder_a  = req_a[int'(grant_id) * WORD_W +: WORD_W];
            adder_b  = req_b[int'(grant_id) * WORD_W +: WORD_W];
            adder_bi = first ? g_sub : sub_reg;
            adder_ci = first ? g_sub : carry_reg;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pick_hit) state_nxt = BURST;
            BURST: if (accept && g_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) state <= IDLE;
        else    state <= state_nxt;
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            first     <= 1'b1;
        end else if (state == IDLE) begin
            if (pick_hit) begin
                grant_id <= pick_id;
                first    <= 1'b1;
            end
        end else if (accept) begin
            carry_reg <= adder_co;
            if (first) begin
                sub_reg <= g_sub;
                first   <= 1'b0;
            end
            if (g_last) begin
                rr_ptr <= ptr_nxt;
                first  <= 1'b1;
            end
        end
    end

    // Response slot: a same-cycle drain and accept keeps valid high.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_co    <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_y     <= adder_y;
            rsp_co    <= adder_co;
            rsp_id    <= grant_id;
            rsp_last  <= g_last;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
